// File: rtl/can_rx_pkg.sv
// -----------------------------------------------------------------------------
// can_rx_pkg
// Shared types and helpers for the CAN/CAN FD receive frame writer.
//   rx_state_e    : writer FSM states
//   rx_hdr_t      : received frame header fields
//   HDR_WORDS     : number of header words at the front of every FIFO entry
//   dlc_to_bytes  : DLC -> payload byte count (classic and FD coding)
//   hdr_word0/1   : header word packing for the FIFO entry
// -----------------------------------------------------------------------------
package can_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic        fdf;
        logic        brs;
        logic        esi;
        logic [3:0]  dlc;
    } rx_hdr_t;

    localparam int HDR_WORDS = 2;

    // Classic frames cap at 8 bytes; FD frames use the extended length table.
    function automatic logic [6:0] dlc_to_bytes(input logic fdf, input logic [3:0] dlc);
        logic [6:0] n;
        if (dlc <= 4'd8) begin
            n = {3'b000, dlc};
        end else if (!fdf) begin
            n = 7'd8;
        end else begin
            case (dlc)
                4'd9:    n = 7'd12;
                4'd10:   n = 7'd16;
                4'd11:   n = 7'd20;
                4'd12:   n = 7'd24;
                4'd13:   n = 7'd32;
                4'd14:   n = 7'd48;
                default: n = 7'd64;
            endcase
        end
        return n;
    endfunction

    // Flags in the top byte, DLC in [23:20]; trunc marks a payload cut to fit the entry.
    function automatic logic [31:0] hdr_word0(input rx_hdr_t h, input logic trunc);
        return {h.fdf, h.brs, h.esi, h.ide, h.rtr, trunc, 2'b00, h.dlc, 20'h00000};
    endfunction

    function automatic logic [31:0] hdr_word1(input rx_hdr_t h);
        return {3'b000, h.id};
    endfunction

endpackage

// File: rtl/can_rx_stage_buf.sv
// -----------------------------------------------------------------------------
// can_rx_stage_buf
// MAX_WORDS x 32 staging register file for one received frame.
//   clk, rst      : clock, synchronous active-high reset (clears all words)
//   clr           : load hdr0/hdr1 into words 0/1 and zero every data word
//   hdr0, hdr1    : header words loaded by clr
//   we, wr_idx, be, wdata : byte-lane write into word wr_idx
//   rd_idx, rd_data       : combinational read of word rd_idx
// -----------------------------------------------------------------------------
module can_rx_stage_buf
    import can_rx_pkg::*;
#(
    parameter int MAX_WORDS = 15,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [31:0]      hdr0,
    input  logic [31:0]      hdr1,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

    logic [31:0] mem_r [MAX_WORDS];

    // Word storage: clear/preload on a new frame, byte-lane writes while collecting.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < MAX_WORDS; w++) begin
                mem_r[w] <= 32'h0000_0000;
            end
        end else if (clr) begin
            // Zeroing the data words here is what makes unsent bytes read back as 0.
            for (int w = 0; w < MAX_WORDS; w++) begin
                if (w == 0) begin
                    mem_r[w] <= hdr0;
                end else if (w == HDR_WORDS - 1) begin
                    mem_r[w] <= hdr1;
                end else begin
                    mem_r[w] <= 32'h0000_0000;
                end
            end
        end else if (we && (wr_idx <= LAST_IDX)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Combinational read port; out-of-range indices read as zero.
    always_comb begin
        rd_data = 32'h0000_0000;
        if (rd_idx <= LAST_IDX) begin
            rd_data = mem_r[rd_idx];
        end else begin
            rd_data = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/can_rx_frame_writer.sv
// -----------------------------------------------------------------------------
// can_rx_frame_writer
// Packs a received CAN/CAN FD frame (header + serial data bytes) into 32-bit
// words and, on commit, writes the whole entry to the RX FIFO as one gapless
// wr burst.
//   clk, rst          : clock, synchronous active-high reset
//   reset_mode        : controller reset mode (like rst, but drop_cnt is held)
//   frame_start, hdr_*: new frame pulse with its header fields
//   byte_valid, byte_data : next data byte
//   frame_ok, frame_err   : commit / discard the current frame
//   ready             : 1 while idle (new frames accepted)
//   wr, data_out      : FIFO write strobe and data
//   drop_cnt          : frames lost because they started while busy (saturating)
// -----------------------------------------------------------------------------
module can_rx_frame_writer
    import can_rx_pkg::*;
#(
    parameter int MAX_WORDS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reset_mode,
    input  logic        frame_start,
    input  logic [28:0] hdr_id,
    input  logic        hdr_ide,
    input  logic        hdr_rtr,
    input  logic        hdr_fdf,
    input  logic        hdr_brs,
    input  logic        hdr_esi,
    input  logic [3:0]  hdr_dlc,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        frame_ok,
    input  logic        frame_err,
    output logic        ready,
    output logic        wr,
    output logic [31:0] data_out,
    output logic [7:0]  drop_cnt
);

    localparam int               IDX_W     = $clog2(MAX_WORDS + 1);
    localparam logic [6:0]       STORE_MAX = 7'(4 * (MAX_WORDS - HDR_WORDS));
    localparam logic [IDX_W-1:0] HDR_IDX   = IDX_W'(HDR_WORDS);

    rx_state_e        state_r;
    logic [6:0]       byte_cnt_r;
    logic [6:0]       stored_r;
    logic [IDX_W-1:0] n_words_r;
    logic [IDX_W-1:0] rd_idx_r;

    rx_hdr_t          hdr_s;
    logic [6:0]       nbytes_s;
    logic             trunc_s;
    logic [6:0]       stored_s;
    logic [6:0]       data_words_s;
    logic [IDX_W-1:0] n_words_s;
    logic             accept_s;
    logic             byte_we_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [3:0]       be_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [31:0]      rd_data_s;

    assign hdr_s = '{id: hdr_id, ide: hdr_ide, rtr: hdr_rtr, fdf: hdr_fdf,
                     brs: hdr_brs, esi: hdr_esi, dlc: hdr_dlc};

    // Entry geometry of the incoming frame, evaluated while its header is valid.
    always_comb begin
        nbytes_s     = 7'd0;
        trunc_s      = 1'b0;
        stored_s     = 7'd0;
        if (hdr_rtr) begin
            nbytes_s = 7'd0;
        end else begin
            nbytes_s = dlc_to_bytes(hdr_fdf, hdr_dlc);
        end
        trunc_s      = (nbytes_s > STORE_MAX);
        stored_s     = trunc_s ? STORE_MAX : nbytes_s;
        data_words_s = (stored_s + 7'd3) >> 2;
        n_words_s    = HDR_IDX + IDX_W'(data_words_s);
    end

    // Buffer control: preload on accepted start, little-endian byte placement.
    always_comb begin
        accept_s  = frame_start && (state_r == IDLE);
        byte_we_s = (state_r == COLLECT) && byte_valid && (byte_cnt_r < stored_r);
        wr_idx_s  = HDR_IDX + IDX_W'(byte_cnt_r[6:2]);
        be_s      = 4'b0001 << byte_cnt_r[1:0];
        // Word 0 is fetched on the commit edge itself, before the FSM reaches DRAIN.
        rd_idx_s  = (state_r == DRAIN) ? rd_idx_r : {IDX_W{1'b0}};
    end

    can_rx_stage_buf #(
        .MAX_WORDS (MAX_WORDS),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_s),
        .hdr0    (hdr_word0(hdr_s, trunc_s)),
        .hdr1    (hdr_word1(hdr_s)),
        .we      (byte_we_s),
        .wr_idx  (wr_idx_s),
        .be      (be_s),
        .wdata   ({4{byte_data}}),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

    // Frame sequencing FSM with registered FIFO-side outputs and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wr         <= 1'b0;
            data_out   <= 32'h0000_0000;
            ready      <= 1'b1;
            drop_cnt   <= 8'd0;
            byte_cnt_r <= 7'd0;
            stored_r   <= 7'd0;
            n_words_r  <= {IDX_W{1'b0}};
            rd_idx_r   <= {IDX_W{1'b0}};
        end else if (reset_mode) begin
            state_r    <= IDLE;
            wr         <= 1'b0;
            data_out   <= 32'h0000_0000;
            ready      <= 1'b1;
            byte_cnt_r <= 7'd0;
            stored_r   <= 7'd0;
            n_words_r  <= {IDX_W{1'b0}};
            rd_idx_r   <= {IDX_W{1'b0}};
        end else begin
            // A start while busy loses that frame; the current one carries on.
            if (frame_start && !ready && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        state_r    <= COLLECT;
                        ready      <= 1'b0;
                        byte_cnt_r <= 7'd0;
                        stored_r   <= stored_s;
                        n_words_r  <= n_words_s;
                    end else begin
                        state_r    <= IDLE;
                        ready      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (frame_err) begin
                        state_r <= IDLE;
                        ready   <= 1'b1;
                    end else begin
                        if (byte_we_s) begin
                            byte_cnt_r <= byte_cnt_r + 7'd1;
                        end
                        if (frame_ok) begin
                            state_r  <= DRAIN;
                            wr       <= 1'b1;
                            data_out <= rd_data_s;
                            rd_idx_r <= {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DRAIN: begin
                    if (rd_idx_r < n_words_r) begin
                        wr       <= 1'b1;
                        data_out <= rd_data_s;
                        rd_idx_r <= rd_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end else begin
                        // ready rises together with the falling edge of wr.
                        state_r  <= IDLE;
                        wr       <= 1'b0;
                        data_out <= 32'h0000_0000;
                        ready    <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    wr       <= 1'b0;
                    data_out <= 32'h0000_0000;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_rx_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_can_rx_frame_writer
// Directed and randomized frames against a cycle-level behavioural model that
// keeps the received bytes in a queue and the pending FIFO words in another.
// -----------------------------------------------------------------------------
module tb_can_rx_frame_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, reset_mode, frame_start;
    logic [28:0] hdr_id;
    logic        hdr_ide, hdr_rtr, hdr_fdf, hdr_brs, hdr_esi;
    logic [3:0]  hdr_dlc;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_ok, frame_err;
    logic        ready, wr;
    logic [31:0] data_out;
    logic [7:0]  drop_cnt;

    can_rx_frame_writer dut (
        .clk(clk), .rst(rst), .reset_mode(reset_mode), .frame_start(frame_start),
        .hdr_id(hdr_id), .hdr_ide(hdr_ide), .hdr_rtr(hdr_rtr), .hdr_fdf(hdr_fdf),
        .hdr_brs(hdr_brs), .hdr_esi(hdr_esi), .hdr_dlc(hdr_dlc),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_ok(frame_ok), .frame_err(frame_err),
        .ready(ready), .wr(wr), .data_out(data_out), .drop_cnt(drop_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    bit          m_collect = 1'b0;
    bit          exp_wr = 1'b0;
    bit          exp_ready = 1'b1;
    logic [31:0] exp_data = 32'h0;
    logic [7:0]  exp_drop = 8'd0;
    logic [31:0] m_q[$];
    logic [7:0]  m_bytes[$];
    int          m_stored = 0;
    logic [31:0] m_w0, m_w1;

    // Captured DUT bursts
    logic [31:0] cap_q[$];
    int          burst_q[$];
    int          cur_burst = 0;

    logic [7:0]  tx_bytes [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_nbytes(input bit fdf, input bit rtr, input int dlc);
        int fd_tab [16];
        fd_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};
        if (rtr) return 0;
        if (fdf) return fd_tab[dlc];
        return (dlc < 8) ? dlc : 8;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_step();
        int nb;
        bit trunc;
        logic [31:0] w;
        if (rst) begin
            m_collect = 1'b0; m_q.delete(); exp_wr = 1'b0; exp_data = 32'h0;
            exp_ready = 1'b1; exp_drop = 8'd0;
        end else if (reset_mode) begin
            m_collect = 1'b0; m_q.delete(); exp_wr = 1'b0; exp_data = 32'h0;
            exp_ready = 1'b1;
        end else begin
            if (frame_start && !exp_ready && exp_drop != 8'd255) exp_drop = exp_drop + 8'd1;
            if (m_collect) begin
                if (frame_err) begin
                    m_collect = 1'b0;
                    exp_ready = 1'b1;
                end else begin
                    if (byte_valid && m_bytes.size() < m_stored) m_bytes.push_back(byte_data);
                    if (frame_ok) begin
                        m_q.delete();
                        m_q.push_back(m_w0);
                        m_q.push_back(m_w1);
                        for (int i = 0; i < (m_stored + 3) / 4; i++) begin
                            w = 32'h0;
                            for (int j = 0; j < 4; j++)
                                if (4 * i + j < m_bytes.size()) w = w | (32'(m_bytes[4 * i + j]) << (8 * j));
                            m_q.push_back(w);
                        end
                        m_collect = 1'b0;
                        exp_wr = 1'b1;
                        exp_data = m_q.pop_front();
                    end
                end
            end else if (exp_wr) begin
                if (m_q.size() != 0) begin
                    exp_data = m_q.pop_front();
                end else begin
                    exp_wr = 1'b0; exp_data = 32'h0; exp_ready = 1'b1;
                end
            end else if (frame_start) begin
                nb = model_nbytes(hdr_fdf, hdr_rtr, int'(hdr_dlc));
                trunc = (nb > 52);
                m_stored = trunc ? 52 : nb;
                m_w0 = (32'(hdr_fdf) << 31) | (32'(hdr_brs) << 30) | (32'(hdr_esi) << 29) |
                       (32'(hdr_ide) << 28) | (32'(hdr_rtr) << 27) | (32'(trunc) << 26) |
                       (32'(hdr_dlc) << 20);
                m_w1 = 32'(hdr_id);
                m_bytes.delete();
                m_collect = 1'b1;
                exp_ready = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Single compare process: every cycle, DUT outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("wr", 32'(wr), 32'(exp_wr));
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            if (exp_wr) chk("data_out", data_out, exp_data);
            if (wr === 1'b1) begin
                cap_q.push_back(data_out);
                cur_burst++;
            end else if (cur_burst > 0) begin
                burst_q.push_back(cur_burst);
                cur_burst = 0;
            end
        end
    end

    task automatic start_frame(input logic [28:0] id, input logic ide, input logic rtr,
                               input logic fdf, input logic brs, input logic esi,
                               input logic [3:0] dlc);
        hdr_id = id; hdr_ide = ide; hdr_rtr = rtr; hdr_fdf = fdf;
        hdr_brs = brs; hdr_esi = esi; hdr_dlc = dlc;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap_max, input bit last_with_ok);
        for (int k = 0; k < n; k++) begin
            byte_valid = 1'b1;
            byte_data = tx_bytes[k % 64];
            if (last_with_ok && k == n - 1) frame_ok = 1'b1;
            tick();
            byte_valid = 1'b0;
            frame_ok = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    task automatic pulse_end(input bit ok, input bit err);
        frame_ok = ok; frame_err = err;
        tick();
        frame_ok = 1'b0; frame_err = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 120 && !done; i++) begin
            tick();
            if (ready === 1'b1 && wr === 1'b0) done = 1'b1;
        end
        tick();
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s: no return to idle within 120 cycles", nm);
        end
    endtask

    task automatic expect_words(input string nm, input logic [31:0] e[$]);
        chk({nm, " word count"}, 32'(cap_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < cap_q.size(); i++)
            chk($sformatf("%s word%0d", nm, i), cap_q[i], e[i]);
        cap_q.delete();
        burst_q.delete();
    endtask

    initial begin
        logic [31:0] e[$];
        int nb, nsend, mode;
        bit fdf, rtr, ide, ok_sent;

        rst = 1'b1; reset_mode = 1'b0; frame_start = 1'b0; hdr_id = 29'h0;
        hdr_ide = 1'b0; hdr_rtr = 1'b0; hdr_fdf = 1'b0; hdr_brs = 1'b0; hdr_esi = 1'b0;
        hdr_dlc = 4'h0; byte_valid = 1'b0; byte_data = 8'h00; frame_ok = 1'b0; frame_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset wr", 32'(wr), 32'd0);
        chk("reset data_out", data_out, 32'h0);
        chk("reset drop_cnt", 32'(drop_cnt), 32'd0);

        // Standard ID, three bytes
        tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB; tx_bytes[2] = 8'hCC;
        start_frame(29'h123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        send_bytes(3, 0, 1'b0);
        pulse_end(1'b1, 1'b0);
        wait_idle("std3");
        chk("std3 burst", 32'(burst_q.size() > 0 ? burst_q[0] : 0), 32'd3);
        chk("std3 ready after", 32'(ready), 32'd1);
        e = '{32'h0030_0000, 32'h0000_0123, 32'h00CC_BBAA};
        expect_words("std3", e);

        // FD extended, 64 bytes -> truncated to 52
        for (int k = 0; k < 64; k++) tx_bytes[k] = 8'(k);
        start_frame(29'h1ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
        send_bytes(64, 0, 1'b0);
        pulse_end(1'b1, 1'b0);
        wait_idle("fd64");
        chk("fd64 burst", 32'(burst_q.size() > 0 ? burst_q[0] : 0), 32'd15);
        chk("fd64 count", 32'(cap_q.size()), 32'd15);
        if (cap_q.size() == 15) begin
            chk("fd64 word0", cap_q[0], 32'hD4F0_0000);
            chk("fd64 word1", cap_q[1], 32'h1ABC_DEF0);
            chk("fd64 word2", cap_q[2], 32'h0302_0100);
            chk("fd64 word14", cap_q[14], 32'h3332_3130);
        end
        cap_q.delete(); burst_q.delete();

        // Remote frame
        start_frame(29'h456, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
        pulse_end(1'b1, 1'b0);
        wait_idle("rtr");
        e = '{32'h0880_0000, 32'h0000_0456};
        expect_words("rtr", e);

        // Aborted frame, then a one-byte frame
        start_frame(29'h222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        send_bytes(5, 1, 1'b0);
        pulse_end(1'b0, 1'b1);
        repeat (4) tick();
        chk("err no wr", 32'(cap_q.size()), 32'd0);
        tx_bytes[0] = 8'h55;
        start_frame(29'h7FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        send_bytes(1, 0, 1'b0);
        pulse_end(1'b1, 1'b0);
        wait_idle("dlc1");
        e = '{32'h0010_0000, 32'h0000_07FF, 32'h0000_0055};
        expect_words("dlc1", e);

        // frame_start during a 15-word drain is dropped
        for (int k = 0; k < 64; k++) tx_bytes[k] = 8'(k);
        start_frame(29'h1ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
        send_bytes(64, 0, 1'b0);
        pulse_end(1'b1, 1'b0);
        tick();
        start_frame(29'h333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        send_bytes(2, 0, 1'b0);
        pulse_end(1'b1, 1'b0);
        wait_idle("drop");
        chk("drop cnt", 32'(drop_cnt), 32'd1);
        chk("drop burst count", 32'(burst_q.size()), 32'd1);
        chk("drop burst len", 32'(burst_q.size() > 0 ? burst_q[0] : 0), 32'd15);
        cap_q.delete(); burst_q.delete();

        // reset_mode on the 4th drain cycle
        start_frame(29'h1ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
        send_bytes(64, 0, 1'b0);
        pulse_end(1'b1, 1'b0);
        repeat (3) tick();
        reset_mode = 1'b1;
        tick();
        reset_mode = 1'b0;
        chk("rm wr", 32'(wr), 32'd0);
        chk("rm ready", 32'(ready), 32'd1);
        chk("rm drop", 32'(drop_cnt), 32'd1);
        tick();
        chk("rm words", 32'(cap_q.size()), 32'd4);
        cap_q.delete(); burst_q.delete();

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            fdf = 1'($urandom_range(1, 0));
            rtr = fdf ? 1'b0 : ($urandom_range(3, 0) == 0);
            ide = 1'($urandom_range(1, 0));
            for (int k = 0; k < 64; k++) tx_bytes[k] = 8'($urandom_range(255, 0));
            if ($urandom_range(3, 0) == 0) begin
                byte_valid = 1'b1; byte_data = 8'hEE; frame_ok = 1'b1; frame_err = 1'($urandom_range(1, 0));
                tick();
                byte_valid = 1'b0; frame_ok = 1'b0; frame_err = 1'b0;
            end
            hdr_dlc = 4'($urandom_range(15, 0));
            nb = model_nbytes(fdf, rtr, int'(hdr_dlc));
            start_frame(ide ? 29'($urandom) : 29'($urandom_range(2047, 0)), ide, rtr, fdf,
                        fdf ? 1'($urandom_range(1, 0)) : 1'b0, 1'($urandom_range(1, 0)), hdr_dlc);
            nsend = $urandom_range(nb + 3, 0);
            mode = $urandom_range(9, 0);
            ok_sent = (mode == 2) && (nsend > 0);
            send_bytes(nsend, 2, ok_sent);
            if (mode == 0) pulse_end(1'b0, 1'b1);
            else if (mode == 1) pulse_end(1'b1, 1'b1);
            else if (!ok_sent) pulse_end(1'b1, 1'b0);
            if (mode >= 2 && $urandom_range(3, 0) == 0) start_frame(29'h0AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
            if ($urandom_range(9, 0) == 0) begin
                repeat ($urandom_range(3, 0)) tick();
                reset_mode = 1'b1;
                tick();
                reset_mode = 1'b0;
            end
            wait_idle("random");
            cap_q.delete(); burst_q.delete();
        end

        // drop_cnt saturation: start held high while busy collecting
        start_frame(29'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        frame_start = 1'b1;
        repeat (260) tick();
        frame_start = 1'b0;
        chk("drop saturate", 32'(drop_cnt), 32'd255);
        reset_mode = 1'b1;
        tick();
        reset_mode = 1'b0;
        tick();
        chk("sat rm ready", 32'(ready), 32'd1);
        chk("sat rm drop held", 32'(drop_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
